// File: rtl/cl_frame_rx.sv
// cl_frame_rx: CameraLink frame receiver that re-times pixels and checks frame geometry and a counting data pattern
module cl_frame_rx #(
    parameter int DW = 16,
    parameter logic [DW-1:0] PATTERN_START = 16'd1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_en,
    input  logic          frame_valid,
    input  logic          line_valid,
    input  logic          data_valid,
    input  logic [DW-1:0] din,
    input  logic [15:0]   app_image_w,
    input  logic [15:0]   app_image_h,
    input  logic          err_clr,
    output logic          pix_valid,
    output logic [DW-1:0] pix_data,
    output logic [11:0]   pix_x,
    output logic [11:0]   pix_y,
    output logic          sof,
    output logic          eol,
    output logic          frame_done,
    output logic [15:0]   meas_w,
    output logic [15:0]   meas_h,
    output logic [15:0]   frame_cnt,
    output logic          err_data,
    output logic          err_width,
    output logic          err_height,
    output logic          err_proto,
    output logic [15:0]   err_data_cnt
);
    localparam logic [1:0] S_SYNC = 2'd0, S_WAIT = 2'd1, S_BLANK = 2'd2, S_LINE = 2'd3;
    logic          r_fv1, r_lv1, r_dv1, r_fv2, r_lv2, r_dv2;
    logic [DW-1:0] r_d1, r_d2, r_exp;
    logic [1:0]    r_state, w_nstate;
    logic [11:0]   r_pixel_cnt, r_line_cnt, w_width, w_lines;
    logic [15:0]   r_meas_w, r_meas_h, r_frame_cnt, r_err_data_cnt;
    logic          r_frame_done, r_err_data, r_err_width, r_err_height, r_err_proto;
    logic          w_fv_rise, w_fv_fall, w_lv_rise, w_lv_fall;
    logic          w_pix, w_mis, w_line_end, w_frame_end;
    // The delayed copy holds the pixel being emitted, so stage 1 acts as one-sample lookahead for eol
    assign w_fv_rise   = r_fv1 & ~r_fv2;
    assign w_fv_fall   = ~r_fv1 & r_fv2;
    assign w_lv_rise   = r_lv1 & ~r_lv2;
    assign w_lv_fall   = ~r_lv1 & r_lv2;
    assign w_pix       = r_fv2 & r_lv2 & r_dv2 & (r_state == S_LINE);
    assign w_mis       = w_pix & (r_d2 != r_exp);
    assign w_line_end  = rx_en & (r_state == S_LINE) & (w_lv_fall | w_fv_fall);
    assign w_frame_end = rx_en & ((r_state == S_BLANK) | (r_state == S_LINE)) & w_fv_fall;
    assign w_width     = r_pixel_cnt + {11'd0, w_pix};
    assign w_lines     = r_line_cnt + {11'd0, w_line_end};
    assign pix_valid    = w_pix;
    assign pix_data     = r_d2;
    assign pix_x        = r_pixel_cnt;
    assign pix_y        = r_line_cnt;
    assign sof          = w_pix & (r_pixel_cnt == 12'd0) & (r_line_cnt == 12'd0);
    assign eol          = w_pix & (~r_lv1 | ~r_fv1);
    assign frame_done   = r_frame_done;
    assign meas_w       = r_meas_w;
    assign meas_h       = r_meas_h;
    assign frame_cnt    = r_frame_cnt;
    assign err_data     = r_err_data;
    assign err_width    = r_err_width;
    assign err_height   = r_err_height;
    assign err_proto    = r_err_proto;
    assign err_data_cnt = r_err_data_cnt;
    // Frame sync state: only a frame whose fv rise is seen after an idle fv is accepted
    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_SYNC:  w_nstate = ~r_fv1 ? S_WAIT : S_SYNC;
            S_WAIT:  w_nstate = w_fv_rise ? S_BLANK : S_WAIT;
            S_BLANK: w_nstate = w_fv_fall ? S_WAIT : (w_lv_rise ? S_LINE : S_BLANK);
            default: w_nstate = w_fv_fall ? S_WAIT : (w_lv_fall ? S_BLANK : S_LINE);
        endcase
        if (!rx_en)
            w_nstate = S_SYNC;
    end
    // Input pipeline is left out of reset so resync sees the true fv level right after reset
    always_ff @(posedge clk) begin
        r_fv1 <= frame_valid;
        r_lv1 <= line_valid;
        r_dv1 <= data_valid;
        r_d1  <= din;
        r_fv2 <= r_fv1;
        r_lv2 <= r_lv1;
        r_dv2 <= r_dv1;
        r_d2  <= r_d1;
    end
    // State, position counters, expected pattern and frame measurements
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_SYNC;
            r_pixel_cnt  <= '0;
            r_line_cnt   <= '0;
            r_exp        <= PATTERN_START;
            r_meas_w     <= '0;
            r_meas_h     <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nstate;
            r_frame_done <= w_frame_end;
            if (w_fv_rise) begin
                r_pixel_cnt <= '0;
                r_line_cnt  <= '0;
                r_exp       <= PATTERN_START;
            end else begin
                r_pixel_cnt <= w_line_end ? 12'd0 : w_width;
                r_line_cnt  <= w_lines;
                r_exp       <= w_pix ? r_exp + DW'(1) : r_exp;
            end
            if (w_line_end)
                r_meas_w <= {4'd0, w_width};
            if (w_frame_end) begin
                r_meas_h    <= {4'd0, w_lines};
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end
    // Sticky error flags; a new error in the clearing cycle still wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_data     <= 1'b0;
            r_err_width    <= 1'b0;
            r_err_height   <= 1'b0;
            r_err_proto    <= 1'b0;
            r_err_data_cnt <= '0;
        end else begin
            r_err_data     <= (r_err_data & ~err_clr) | w_mis;
            r_err_width    <= (r_err_width & ~err_clr) | (w_line_end & ({4'd0, w_width} != app_image_w));
            r_err_height   <= (r_err_height & ~err_clr) | (w_frame_end & ({4'd0, w_lines} != app_image_h));
            r_err_proto    <= (r_err_proto & ~err_clr) | (w_lv_rise & ~r_fv1) | (w_frame_end & (r_state == S_LINE));
            r_err_data_cnt <= err_clr ? {15'd0, w_mis} :
                              (w_mis & (r_err_data_cnt != 16'hFFFF)) ? r_err_data_cnt + 16'd1 : r_err_data_cnt;
        end
    end
endmodule

// File: tb/tb_cl_frame_rx.sv
// tb_cl_frame_rx: directed frames with a scoreboard of expected pixels and frame results
module tb_cl_frame_rx;
    logic        clk = 1'b0, rst = 1'b1, rx_en = 1'b0, err_clr = 1'b0;
    logic        frame_valid = 1'b0, line_valid = 1'b0, data_valid = 1'b0;
    logic [15:0] din = '0, app_image_w = 16'd4, app_image_h = 16'd3;
    logic        pix_valid, sof, eol, frame_done;
    logic [15:0] pix_data, meas_w, meas_h, frame_cnt, err_data_cnt;
    logic [11:0] pix_x, pix_y;
    logic        err_data, err_width, err_height, err_proto;

    typedef struct packed {logic [15:0] d; logic [11:0] x; logic [11:0] y; logic s; logic e;} pix_t;
    typedef struct packed {logic [15:0] w; logic [15:0] h; logic [15:0] fc;} frm_t;
    pix_t pq[$];
    frm_t fq[$];
    pix_t ma, me;
    frm_t fa, fe;
    int n_chk = 0, n_fail = 0, n_fd = 0, fd0;
    int widths[3];
    int bad_pos = 0, gap_y = -1, gap_x = 0, rst_after = -1;
    logic [15:0] bad_val = '0;
    bit abort_last = 1'b0;

    cl_frame_rx #(.PATTERN_START(16'd1), .DW(16)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en),
        .frame_valid(frame_valid), .line_valid(line_valid), .data_valid(data_valid),
        .din(din), .app_image_w(app_image_w), .app_image_h(app_image_h), .err_clr(err_clr),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .sof(sof), .eol(eol), .frame_done(frame_done),
        .meas_w(meas_w), .meas_h(meas_h), .frame_cnt(frame_cnt),
        .err_data(err_data), .err_width(err_width), .err_height(err_height), .err_proto(err_proto),
        .err_data_cnt(err_data_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid) begin
                ma = {pix_data, pix_x, pix_y, sof, eol};
                if (pq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pix_unexpected: got %0h expected none", ma);
                end else begin
                    me = pq.pop_front();
                    chk("pix{data,x,y,sof,eol}", 64'(ma), 64'(me));
                end
            end
            if (frame_done) begin
                n_fd++;
                fa = {meas_w, meas_h, frame_cnt};
                if (fq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got %0h expected none", fa);
                end else begin
                    fe = fq.pop_front();
                    chk("frame{w,h,cnt}", 64'(fa), 64'(fe));
                end
            end
        end
    end

    task automatic drive(input logic f, input logic l, input logic v, input logic [15:0] d);
        frame_valid = f;
        line_valid  = l;
        data_valid  = v;
        din         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        drive(0, 0, 0, 0);
        err_clr = 1'b0;
    endtask

    task automatic send_frame(input int nl);
        int v = 1;
        bit acc = 1'b1;
        logic [15:0] d;
        repeat (2) drive(1, 0, 0, 0);
        for (int y = 0; y < nl; y++) begin
            for (int i = 0; i < widths[y]; i++) begin
                if (y == gap_y && i == gap_x)
                    repeat (2) drive(1, 1, 0, 16'hDEAD);
                d = (v == bad_pos) ? bad_val : 16'(v);
                if (acc)
                    pq.push_back(pix_t'({d, 12'(i), 12'(y), (i == 0 && y == 0), (i == widths[y] - 1)}));
                drive(1, 1, 1, d);
                v++;
            end
            if (abort_last && y == nl - 1)
                drive(0, 1, 0, 0);
            else
                repeat (2) drive(1, 0, 0, 0);
            if (y == rst_after) begin
                rst = 1'b1;
                repeat (2) drive(1, 0, 0, 0);
                rst = 1'b0;
                acc = 1'b0;
            end
        end
        repeat (3) drive(0, 0, 0, 0);
    endtask

    initial begin
        rx_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_pix_valid", 64'(pix_valid), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_meas", 64'({meas_w, meas_h, frame_cnt}), 64'd0);
        chk("rst_errs", 64'({err_data, err_width, err_height, err_proto, err_data_cnt}), 64'd0);
        repeat (2) drive(0, 0, 0, 0);

        widths = '{4, 4, 4};
        fq.push_back(frm_t'({16'd4, 16'd3, 16'd1}));
        send_frame(3);
        chk("clean_errs", 64'({err_data, err_width, err_height, err_proto}), 64'd0);
        chk("clean_pix_drained", 64'(pq.size()), 64'd0);

        bad_pos = 6;
        bad_val = 16'h00FF;
        fq.push_back(frm_t'({16'd4, 16'd3, 16'd2}));
        send_frame(3);
        bad_pos = 0;
        chk("bad_err_data", 64'(err_data), 64'd1);
        chk("bad_err_data_cnt", 64'(err_data_cnt), 64'd1);
        clear_errs();
        chk("clr_err_data", 64'({err_data, err_data_cnt}), 64'd0);

        widths = '{4, 5, 4};
        fq.push_back(frm_t'({16'd4, 16'd3, 16'd3}));
        send_frame(3);
        chk("wide_err_width", 64'(err_width), 64'd1);
        chk("wide_other_errs", 64'({err_data, err_height}), 64'd0);
        clear_errs();
        chk("clr_err_width", 64'(err_width), 64'd0);
        widths = '{4, 4, 4};

        fd0 = n_fd;
        rst_after = 0;
        send_frame(3);
        rst_after = -1;
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        fq.push_back(frm_t'({16'd4, 16'd3, 16'd1}));
        send_frame(3);
        chk("midrst_fd_count", 64'(n_fd - fd0), 64'd1);
        chk("midrst_frame_cnt_after", 64'(frame_cnt), 64'd1);

        repeat (2) drive(0, 1, 1, 16'd5);
        repeat (2) drive(0, 0, 0, 0);
        chk("lv_no_fv_err_proto", 64'(err_proto), 64'd1);
        clear_errs();
        chk("clr_err_proto", 64'(err_proto), 64'd0);
        abort_last = 1'b1;
        fq.push_back(frm_t'({16'd4, 16'd3, 16'd2}));
        send_frame(3);
        abort_last = 1'b0;
        chk("abort_err_proto", 64'(err_proto), 64'd1);
        chk("abort_meas_h", 64'(meas_h), 64'd3);
        chk("abort_err_height", 64'(err_height), 64'd0);
        clear_errs();

        gap_y = 0;
        gap_x = 2;
        fq.push_back(frm_t'({16'd4, 16'd3, 16'd3}));
        send_frame(3);
        gap_y = -1;
        chk("gap_errs", 64'({err_data, err_width, err_data_cnt}), 64'd0);

        repeat (5) drive(0, 0, 0, 0);
        chk("final_pix_queue", 64'(pq.size()), 64'd0);
        chk("final_frame_queue", 64'(fq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "timeout");
    end
endmodule
